// File: rtl/arc4_seq.sv
// arc4_seq: top-level sequencer for one ARC4 pass (init -> ksa -> prga).
// Owns the shared S-memory port and guards every stage with a watchdog.
module arc4_seq #(
    parameter int               TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYCLES = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       done,
    output logic       err,
    output logic [1:0] stage,
    output logic       en_init,
    output logic       en_ksa,
    output logic       en_prga,
    input  logic       rdy_init,
    input  logic       rdy_ksa,
    input  logic       rdy_prga,
    input  logic [7:0] addr_init,
    input  logic [7:0] wrdata_init,
    input  logic       wren_init,
    input  logic [7:0] addr_ksa,
    input  logic [7:0] wrdata_ksa,
    input  logic       wren_ksa,
    input  logic [7:0] addr_prga,
    input  logic [7:0] wrdata_prga,
    input  logic       wren_prga,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_I_GO,
        ST_I_ACK,
        ST_I_RUN,
        ST_K_GO,
        ST_K_ACK,
        ST_K_RUN,
        ST_P_GO,
        ST_P_ACK,
        ST_P_RUN,
        ST_FIN,
        ST_ERR
    } state_t;

    localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic [TMO_W-1:0] cnt_inc;
    logic             in_stage;
    logic             go_entry;
    logic             tmo_hit;

    // State and watchdog registers; reset parks the sequencer in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Classify the current state as belonging to a watched stage.
    always_comb begin
        in_stage = 1'b0;
        unique case (state_q)
            ST_I_GO, ST_I_ACK, ST_I_RUN,
            ST_K_GO, ST_K_ACK, ST_K_RUN,
            ST_P_GO, ST_P_ACK, ST_P_RUN: in_stage = 1'b1;
            default:                     in_stage = 1'b0;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    // A stage times out when its cycle count would reach the limit.
    assign tmo_hit = in_stage
                   && (TMO_CYCLES != '0)
                   && (cnt_inc == TMO_CYCLES);

    // Next-state: GO waits for ready, ACK for the drop, RUN for the rise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en)        state_d = ST_I_GO;
            ST_I_GO:  if (rdy_init)  state_d = ST_I_ACK;
            ST_I_ACK: if (!rdy_init) state_d = ST_I_RUN;
            ST_I_RUN: if (rdy_init)  state_d = ST_K_GO;
            ST_K_GO:  if (rdy_ksa)   state_d = ST_K_ACK;
            ST_K_ACK: if (!rdy_ksa)  state_d = ST_K_RUN;
            ST_K_RUN: if (rdy_ksa)   state_d = ST_P_GO;
            ST_P_GO:  if (rdy_prga)  state_d = ST_P_ACK;
            ST_P_ACK: if (!rdy_prga) state_d = ST_P_RUN;
            ST_P_RUN: if (rdy_prga)  state_d = ST_FIN;
            ST_FIN:                  state_d = ST_IDLE;
            ST_ERR:                  state_d = ST_ERR;
            default:                 state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_ERR;
        end
    end

    // Watchdog count restarts on every GO entry and runs through the stage.
    always_comb begin
        go_entry = (state_d != state_q)
                 && ((state_d == ST_I_GO)
                  || (state_d == ST_K_GO)
                  || (state_d == ST_P_GO));
        cnt_d = cnt_q;
        if (go_entry) begin
            cnt_d = '0;
        end else if (in_stage) begin
            cnt_d = cnt_inc;
        end
    end

    // Status outputs and start pulses, decoded from the current state.
    always_comb begin
        rdy     = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        stage   = 2'd0;
        en_init = 1'b0;
        en_ksa  = 1'b0;
        en_prga = 1'b0;
        unique case (state_q)
            ST_IDLE: rdy = 1'b1;
            ST_I_GO: begin
                stage   = 2'd1;
                en_init = rdy_init;
            end
            ST_I_ACK, ST_I_RUN: stage = 2'd1;
            ST_K_GO: begin
                stage  = 2'd2;
                en_ksa = rdy_ksa;
            end
            ST_K_ACK, ST_K_RUN: stage = 2'd2;
            ST_P_GO: begin
                stage   = 2'd3;
                en_prga = rdy_prga;
            end
            ST_P_ACK, ST_P_RUN: stage = 2'd3;
            ST_FIN:  done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: rdy  = 1'b0;
        endcase
    end

    // S-port owner mux; only the active stage reaches the memory.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        unique case (state_q)
            ST_I_GO, ST_I_ACK, ST_I_RUN: begin
                s_addr   = addr_init;
                s_wrdata = wrdata_init;
                s_wren   = wren_init;
            end
            ST_K_GO, ST_K_ACK, ST_K_RUN: begin
                s_addr   = addr_ksa;
                s_wrdata = wrdata_ksa;
                s_wren   = wren_ksa;
            end
            ST_P_GO, ST_P_ACK, ST_P_RUN: begin
                s_addr   = addr_prga;
                s_wrdata = wrdata_prga;
                s_wren   = wren_prga;
            end
            default: s_wren = 1'b0;
        endcase
    end

endmodule

// File: doc/arc4_seq.md
Name: arc4_seq

Overview:
- Top-level sequencer for one ARC4 decryption pass: runs init, then ksa, then prga, using each sub-block's en/rdy handshake.
- Owns the single port of the shared S memory (s_mem) and muxes address, write-data and write-enable from whichever stage is active.
- Adds a per-stage watchdog and a sticky error flag, so a hung sub-block is visible to the top level instead of stalling forever.

Parameters:
- TMO_W, 16, width of the watchdog counter.
- TMO_CYCLES, 16'hFFFF, maximum cycles allowed per stage, counted from entry into that stage's GO state; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; honoured only in a cycle where rdy=1
- rdy  out  1  sequencer idle and able to accept en
- done  out  1  one-cycle pulse when prga completes
- err  out  1  sticky watchdog timeout flag
- stage  out  2  active stage: 0 idle, 1 init, 2 ksa, 3 prga
- en_init / en_ksa / en_prga  out  1 each  one-cycle start pulse to each sub-block
- rdy_init / rdy_ksa / rdy_prga  in  1 each  sub-block ready
- addr_init, wrdata_init  in  8 each;  wren_init  in  1  init's S-port request
- addr_ksa, wrdata_ksa  in  8 each;  wren_ksa  in  1  ksa's S-port request
- addr_prga, wrdata_prga  in  8 each;  wren_prga  in  1  prga's S-port request
- s_addr, s_wrdata  out  8 each;  s_wren  out  1  to the s_mem port

Behaviour:
- Reset is asynchronous, active-low, on clk. In reset: state=IDLE, rdy=1, done=0, err=0, stage=0, all en_*=0, s_addr=0, s_wrdata=0, s_wren=0, watchdog counter=0.
- States: IDLE, I_GO, I_ACK, I_RUN, K_GO, K_ACK, K_RUN, P_GO, P_ACK, P_RUN, FIN, ERR.
- IDLE: rdy=1. en=1 -> I_GO. en while rdy=0 is ignored, with no queuing.
- X_GO (X = I, K, P):
  - en_X = rdy_X, so the start pulse goes out only when the sub-block is ready.
  - rdy_X=1 -> X_ACK; otherwise stay in X_GO.
  - The watchdog counter clears on entry to X_GO and increments every cycle in X_GO, X_ACK and X_RUN.
- X_ACK: wait for rdy_X=0 (start accepted), then -> X_RUN. rdy_X is not sampled as "done" here; this prevents mistaking the stale ready for completion.
- X_RUN: rdy_X=1 -> next stage's GO (I->K_GO, K->P_GO, P->FIN).
- FIN: done=1 for exactly one cycle, then -> IDLE. rdy stays 0 during FIN, so the earliest restart en is sampled in the cycle after done.
- Watchdog:
  - TMO_CYCLES!=0 and the counter reaches TMO_CYCLES in any X_GO/X_ACK/X_RUN -> ERR.
  - Timeout has priority over a same-cycle progress transition.
- ERR: err=1, rdy=0, all en_*=0, S port idle. Exit only via reset.
- stage output: 1 in I_*, 2 in K_*, 3 in P_*, 0 in IDLE/FIN/ERR.
- en_* is asserted at most once per pass, exactly one cycle wide, and never more than one at a time.
- S-port mux is purely combinational on state:
  - I_* states route the init inputs; K_* route ksa; P_* route prga.
  - IDLE/FIN/ERR drive addr=0, wrdata=0, wren=0.
  - Requests from a non-owning stage are ignored entirely, including its wren.
- Reset mid-operation: returns to IDLE immediately (asynchronously); the S port goes idle the same instant, and there are no en_* glitches.
- A sub-block dropping rdy while the sequencer is in another stage has no effect.
- Back-to-back passes are allowed: en on the first cycle rdy=1 after FIN starts a new pass.

Test Plan:
- Nominal pass, with stub sub-blocks that drop rdy one cycle after en and raise it after 256 (init), 768 (ksa) and 1000 (prga) cycles:
  - en_init, en_ksa and en_prga each pulse once, in order.
  - stage goes 1->2->3->0, done pulses once, rdy returns to 1.
- Mux isolation: init stub drives addr=0x12/wren=1 and ksa stub drives addr=0x34/wren=1 concurrently.
  - During stage=1, s_addr=0x12; during stage=2, s_addr=0x34; in IDLE, s_wren=0.
- Stale ready: ksa stub holds rdy=1 for 3 cycles after en_ksa, then drops it for 10 cycles.
  - The sequencer stays in K_ACK/K_RUN and does not advance until rdy_ksa rises again.
- Watchdog with TMO_CYCLES=50: prga stub never re-raises rdy.
  - err=1 at cycle 50 after entering P_GO; rdy stays 0; a subsequent en is ignored; reset clears err.
- Reset mid-ksa: rst_n=0 for 2 cycles.
  - All outputs take their reset values asynchronously; a new en restarts at en_init.
- en while busy, and back-to-back: pulse en during stage=2 -> ignored. After done, assert en in the first cycle rdy=1 -> a second full pass with identical pulse ordering.
